// File: rtl/logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : logic_unit_pipe
// Description : Two-stage valid/ready pipelined ARM logical unit
//               (AND/EOR/ORR/BIC/MOV/MVN/TST/TEQ) with NZC flags.
//               Optional macro LOGIC_UNIT_OPCOUNT_EN adds a 16-bit count of
//               output handshakes on port op_count.
// Revision    : 1.0 - initial release
// ============================================================================
module logic_unit_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             out_wr,
    output logic [2:0]       out_flags
`ifdef LOGIC_UNIT_OPCOUNT_EN
    ,
    output logic [15:0]      op_count
`endif
);

    localparam logic [2:0] c_OP_AND = 3'b000;
    localparam logic [2:0] c_OP_EOR = 3'b001;
    localparam logic [2:0] c_OP_ORR = 3'b010;
    localparam logic [2:0] c_OP_BIC = 3'b011;
    localparam logic [2:0] c_OP_MOV = 3'b100;
    localparam logic [2:0] c_OP_MVN = 3'b101;
    localparam logic [2:0] c_OP_TST = 3'b110;
    localparam logic [2:0] c_OP_TEQ = 3'b111;

    // Stage S1: captured operand bundle
    logic             r_s1_valid;
    logic [2:0]       r_s1_op;
    logic [WIDTH-1:0] r_s1_a;
    logic [WIDTH-1:0] r_s1_b;
    logic             r_s1_cin;

    // Stage S2: result bundle, drives the outputs directly
    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_y;
    logic             r_out_wr;
    logic [2:0]       r_out_flags;

    logic             w_s2_adv;
    logic             w_s1_adv;
    logic             w_accept;
    logic [WIDTH-1:0] w_y;
    logic             w_wr;
    logic [2:0]       w_flags;

    assign w_s2_adv = !r_out_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign w_accept = in_valid && w_s1_adv;
    assign in_ready = w_s1_adv;

    always_comb begin
        w_y  = '0;
        w_wr = 1'b1;
        case (r_s1_op)
            c_OP_AND: w_y = r_s1_a & r_s1_b;
            c_OP_EOR: w_y = r_s1_a ^ r_s1_b;
            c_OP_ORR: w_y = r_s1_a | r_s1_b;
            c_OP_BIC: w_y = r_s1_a & ~r_s1_b;
            c_OP_MOV: w_y = r_s1_b;
            c_OP_MVN: w_y = ~r_s1_b;
            c_OP_TST: begin
                w_y  = r_s1_a & r_s1_b;
                w_wr = 1'b0;
            end
            c_OP_TEQ: begin
                w_y  = r_s1_a ^ r_s1_b;
                w_wr = 1'b0;
            end
            default: w_y = '0;
        endcase
    end

    // Carry is a pass-through of the shifter carry; nothing here generates one
    assign w_flags = {w_y[WIDTH-1], (w_y == '0), r_s1_cin};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_op    <= '0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_cin   <= 1'b0;
        end else if (w_s1_adv) begin
            r_s1_valid <= in_valid;
            if (w_accept) begin
                r_s1_op  <= in_op;
                r_s1_a   <= in_a;
                r_s1_b   <= in_b;
                r_s1_cin <= in_cin;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
            r_out_wr    <= 1'b0;
            r_out_flags <= '0;
        end else if (w_s2_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_y     <= w_y;
                r_out_wr    <= w_wr;
                r_out_flags <= w_flags;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_y     = r_out_y;
    assign out_wr    = r_out_wr;
    assign out_flags = r_out_flags;

`ifdef LOGIC_UNIT_OPCOUNT_EN
    logic [15:0] r_op_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op_count <= '0;
        end else if (r_out_valid && out_ready) begin
            r_op_count <= r_op_count + 16'd1;
        end
    end

    assign op_count = r_op_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_logic_unit_pipe
// Description : Self-checking bench for logic_unit_pipe (WIDTH=8): directed
//               vector table, stall/reset sequences and a randomized run
//               against a behavioural scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_logic_unit_pipe;

    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_y;
    logic             out_wr;
    logic [2:0]       out_flags;
`ifdef LOGIC_UNIT_OPCOUNT_EN
    logic [15:0]      op_count;
`endif

    logic_unit_pipe #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .out_wr    (out_wr),
        .out_flags (out_flags)
`ifdef LOGIC_UNIT_OPCOUNT_EN
        ,
        .op_count  (op_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] y;
        logic             wr;
        logic [2:0]       flags;
    } vec_t;

    // Expected result packed as {y, wr, flags}
    typedef logic [WIDTH+3:0] res_t;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: the ARM logical ops written straight from the op table
    function automatic res_t model(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b, input logic cin);
        logic [WIDTH-1:0] y;
        logic wr;
        wr = (op < 3'd6);
        case (op)
            3'd0, 3'd6: y = a & b;
            3'd1, 3'd7: y = a ^ b;
            3'd2:       y = a | b;
            3'd3:       y = a & ~b;
            3'd4:       y = b;
            default:    y = ~b;
        endcase
        return {y, wr, y[WIDTH-1], (y == 0), cin};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [WIDTH-1:0] a,
                         input logic [WIDTH-1:0] b, input logic cin);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
    endtask

    function automatic res_t outs();
        return {out_y, out_wr, out_flags};
    endfunction

    vec_t vecs[8];
    res_t q[$];
    res_t held, exp_r;
    int   hs_count;
    logic prev_stall;

    initial begin
        vecs[0] = '{3'd1, 8'hF0, 8'h3C, 1'b0, 8'hCC, 1'b1, 3'b100};
        vecs[1] = '{3'd0, 8'hA5, 8'h0F, 1'b1, 8'h05, 1'b1, 3'b001};
        vecs[2] = '{3'd2, 8'hA5, 8'h0F, 1'b1, 8'hAF, 1'b1, 3'b101};
        vecs[3] = '{3'd3, 8'hA5, 8'h0F, 1'b1, 8'hA0, 1'b1, 3'b101};
        vecs[4] = '{3'd4, 8'hA5, 8'h0F, 1'b1, 8'h0F, 1'b1, 3'b001};
        vecs[5] = '{3'd5, 8'hA5, 8'h0F, 1'b1, 8'hF0, 1'b1, 3'b101};
        vecs[6] = '{3'd7, 8'h5A, 8'h5A, 1'b1, 8'h00, 1'b0, 3'b011};
        vecs[7] = '{3'd6, 8'h80, 8'h80, 1'b0, 8'h80, 1'b0, 3'b100};

        reset     = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 3'd0, '0, '0, 1'b0);
        tick();
        tick();
        reset = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", out_valid, 0);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_outputs", outs(), 0);
        tick();

        // Directed table, one bundle per cycle; vector k must appear at cycle k+2
        for (int c = 0; c < 12; c++) begin
            if (c < 8) drive(1'b1, vecs[c].op, vecs[c].a, vecs[c].b, vecs[c].cin);
            else       drive(1'b0, 3'd0, '0, '0, 1'b0);
            @(negedge clk);
            if (c < 8) chk("table_in_ready", in_ready, 1);
            chk($sformatf("table_valid_c%0d", c), out_valid, (c >= 2 && c < 10));
            if (c >= 2 && c < 10)
                chk($sformatf("table_vec%0d", c - 2), outs(),
                    {vecs[c-2].y, vecs[c-2].wr, vecs[c-2].flags});
            tick();
        end

        // Stall: two bundles fill the pipe, third is refused until out_ready rises
        out_ready = 1'b0;
        drive(1'b1, 3'd2, 8'h11, 8'h22, 1'b0);
        @(negedge clk);
        chk("stall_rdy0", in_ready, 1);
        tick();
        drive(1'b1, 3'd5, 8'h00, 8'h0F, 1'b1);
        @(negedge clk);
        chk("stall_rdy1", in_ready, 1);
        tick();
        drive(1'b1, 3'd3, 8'hFF, 8'h0F, 1'b0);
        @(negedge clk);
        chk("stall_rdy2", in_ready, 0);
        chk("stall_out0", outs(), model(3'd2, 8'h11, 8'h22, 1'b0));
        tick();
        @(negedge clk);
        chk("stall_rdy2_hold", in_ready, 0);
        chk("stall_out0_hold", outs(), model(3'd2, 8'h11, 8'h22, 1'b0));
        tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("stall_release_rdy", in_ready, 1);
        chk("stall_drain0", {out_valid, outs()}, {1'b1, model(3'd2, 8'h11, 8'h22, 1'b0)});
        tick();
        drive(1'b0, 3'd0, '0, '0, 1'b0);
        @(negedge clk);
        chk("stall_drain1", {out_valid, outs()}, {1'b1, model(3'd5, 8'h00, 8'h0F, 1'b1)});
        tick();
        @(negedge clk);
        chk("stall_drain2", {out_valid, outs()}, {1'b1, model(3'd3, 8'hFF, 8'h0F, 1'b0)});
        tick();
        @(negedge clk);
        chk("stall_empty", out_valid, 0);
        tick();

        // Reset with both stages full and output stalled
        out_ready = 1'b0;
        drive(1'b1, 3'd4, 8'h00, 8'h77, 1'b1);
        tick();
        drive(1'b1, 3'd4, 8'h00, 8'h66, 1'b1);
        tick();
        drive(1'b0, 3'd0, '0, '0, 1'b0);
        @(negedge clk);
        chk("full_out_valid", out_valid, 1);
        chk("full_in_ready", in_ready, 0);
        reset = 1'b1;
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_out_valid", out_valid, 0);
        chk("rst_mid_in_ready", in_ready, 1);
        chk("rst_mid_outputs", outs(), 0);
`ifdef LOGIC_UNIT_OPCOUNT_EN
        chk("rst_op_count", op_count, 0);
`endif
        for (int c = 0; c < 4; c++) begin
            tick();
            @(negedge clk);
            chk("rst_no_ghost", out_valid, 0);
        end
        tick();

        // Randomized run against the scoreboard queue
        hs_count   = 0;
        prev_stall = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            drive(1'($urandom), 3'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
            out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (prev_stall) chk("rand_hold_stable", {out_valid, outs()}, {1'b1, held});
            if (out_valid && out_ready) begin
                hs_count++;
                if (q.size() == 0) chk("rand_unexpected_out", 1, 0);
                else begin
                    exp_r = q.pop_front();
                    chk("rand_out", outs(), exp_r);
                end
            end
            if (in_valid && in_ready) q.push_back(model(in_op, in_a, in_b, in_cin));
            prev_stall = out_valid && !out_ready;
            held       = outs();
            tick();
        end

        drive(1'b0, 3'd0, '0, '0, 1'b0);
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) begin
                hs_count++;
                if (q.size() == 0) chk("drain_unexpected_out", 1, 0);
                else begin
                    exp_r = q.pop_front();
                    chk("drain_out", outs(), exp_r);
                end
            end
            tick();
        end
        chk("drain_queue_empty", q.size(), 0);
`ifdef LOGIC_UNIT_OPCOUNT_EN
        @(negedge clk);
        chk("op_count", op_count, 16'(hs_count));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, two-stage pipelined bitwise logic unit for the ALU datapath. It is the successor to the fixed 3-bit single-function XOR gate.
- Executes the ARM logical data-processing group: AND, EOR, ORR, BIC, MOV, MVN, TST and TEQ.
- Produces ARM NZC flags alongside the result.
- Uses valid/ready handshakes on both sides, so it can sit between an operand-fetch stage and writeback with backpressure.

Parameters:
- WIDTH, 32, operand/result width in bits (legal range 2..64).

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  operand bundle valid
- in_ready  out  1  unit accepts bundle this cycle
- in_op  in  3  operation select (encoding below)
- in_a  in  WIDTH  first operand (Rn)
- in_b  in  WIDTH  second operand (shifter output)
- in_cin  in  1  shifter carry-out, passed through as C
- out_valid  out  1  result bundle valid
- out_ready  in  1  downstream accepts bundle
- out_y  out  WIDTH  result
- out_wr  out  1  result must be written to Rd (0 for TST/TEQ)
- out_flags  out  3  {N,Z,C}

Behaviour:
- Op encoding:
  - 000 AND a&b
  - 001 EOR a^b
  - 010 ORR a|b
  - 011 BIC a&~b
  - 100 MOV b
  - 101 MVN ~b
  - 110 TST a&b, out_wr=0
  - 111 TEQ a^b, out_wr=0
- Flags:
  - N = y[WIDTH-1]
  - Z = (y == 0)
  - C = in_cin captured with the bundle
  - y is always computed and presented, including for TST/TEQ.
- Stage S1: registers op, a, b, cin on an accept (in_valid & in_ready).
- Stage S2: registers the computed y, out_wr and flags. S2 drives out_* directly from registers; there is no combinational in→out path.
- Advance rules:
  - s2_adv = !out_valid | out_ready
  - s1_adv = !s1_valid | s2_adv
  - in_ready = s1_adv
  - in_ready does not depend combinationally on in_valid.
- Latency: exactly 2 cycles from accept to out_valid when unstalled. Throughput is 1 bundle/cycle.
- Backpressure:
  - While out_valid & !out_ready, S2 holds all outputs stable.
  - S1 holds if it is occupied.
  - in_ready drops only when both stages are full.
- Simultaneous events: with both stages full and out_ready=1 on the same cycle as in_valid=1, S2 takes S1's bundle, S1 takes the new bundle, and nothing is dropped or duplicated.
- Ordering: bundles leave in strict acceptance order. Each accepted bundle appears exactly once.
- Reset:
  - Valid bits and data registers: s1_valid=0, out_valid=0, out_y=0, out_flags=0, out_wr=0.
  - Handshake outputs: in_ready reads 1 from the first cycle after reset deasserts.
  - In-flight bundles are discarded, with no partial output.
  - Reset asserted mid-stall clears both stages in the same cycle.
- Width: all operations are bitwise at WIDTH. There is no carry chain; C is never generated internally.

Optional Feature:
- Macro: LOGIC_UNIT_OPCOUNT_EN.
- Defined:
  - Adds output port op_count (out, 16 bits), counting handshakes completed at the output (out_valid & out_ready).
  - Reset value is 0; the counter wraps from 0xFFFF to 0x0000.
  - Increments in the cycle after a completed handshake.
- Undefined: the port and counter are absent, and all other behaviour is identical.

Test Plan (WIDTH=8 unless stated):
1. Reset, then a=8'hF0, b=8'h3C, op=EOR, cin=0, out_ready=1 → 2 cycles later y=8'hCC, wr=1, flags={1,0,0}.
2. Back-to-back bundles, one per cycle, of AND, ORR, BIC, MOV, MVN (a=8'hA5, b=8'h0F, cin=1) → consecutive cycles give y=05,AF,A0,0F,F0; wr=1 for all; flags {0,0,1},{1,0,1},{1,0,1},{0,0,1},{1,0,1}.
3. TEQ a=8'h5A, b=8'h5A → y=00, wr=0, flags={0,1,cin}. TST a=8'h80, b=8'h80 → y=80, wr=0, N=1.
4. Stall: hold out_ready=0 and offer 3 bundles → 2 accepted, in_ready=0 on the third, outputs stable. Raise out_ready → the third is accepted the same cycle, and all 3 emerge in order.
5. Reset asserted with both stages full and out_valid=1 → next cycle out_valid=0, in_ready=1, and the held bundles never appear.
6. WIDTH=32 with LOGIC_UNIT_OPCOUNT_EN: 70000 bundles with random op and a random out_ready pattern → every output matches the reference model, and op_count=70000 mod 65536 = 4464.
